// File: rtl/demux_8_seq_if.sv
// rtl/demux_8_seq_if.sv - handshake/bus bundle for the registered 1-to-8 demultiplexer
// Optional frame_par signal exists only when DEMUX8_PARITY_EN is defined.
interface demux_8_seq_if #(
   parameter int W = 1
);
   logic [W-1:0]   din;
   logic           din_valid;
   logic           mode;
   logic           s0;
   logic           s1;
   logic           s2;
   logic           ptr_clr;
   logic [8*W-1:0] y;
   logic [7:0]     y_strobe;
   logic [2:0]     ptr;
   logic           frame_done;
`ifdef DEMUX8_PARITY_EN
   logic           frame_par;

   modport master (
      output din, din_valid, mode, s0, s1, s2, ptr_clr,
      input  y, y_strobe, ptr, frame_done, frame_par
   );
   modport slave (
      input  din, din_valid, mode, s0, s1, s2, ptr_clr,
      output y, y_strobe, ptr, frame_done, frame_par
   );
`else
   modport master (
      output din, din_valid, mode, s0, s1, s2, ptr_clr,
      input  y, y_strobe, ptr, frame_done
   );
   modport slave (
      input  din, din_valid, mode, s0, s1, s2, ptr_clr,
      output y, y_strobe, ptr, frame_done
   );
`endif
endinterface

// File: rtl/demux_8_seq.sv
// rtl/demux_8_seq.sv - registered 1-to-8 demultiplexer with addressed and auto-scan modes
// Optional frame parity output enabled by DEMUX8_PARITY_EN.
module demux_8_seq #(
   parameter int W = 1
) (
   input logic           clk,
   input logic           rst,
   demux_8_seq_if.slave  bus
);
   logic [8*W-1:0] y_r;
   logic [8*W-1:0] y_next;
   logic [7:0]     strobe_r;
   logic [2:0]     ptr_r;
   logic           done_r;
   logic [2:0]     c;

   // ptr_clr in auto mode forces the current write onto channel 0
   always_comb begin
      c = bus.mode ? (bus.ptr_clr ? 3'd0 : ptr_r) : {bus.s2, bus.s1, bus.s0};
      y_next = y_r;
      y_next[int'(c)*W +: W] = bus.din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_r      <= '0;
         strobe_r <= '0;
         ptr_r    <= '0;
         done_r   <= 1'b0;
      end else begin
         strobe_r <= '0;
         done_r   <= 1'b0;
         if (bus.din_valid) begin
            y_r      <= y_next;
            strobe_r <= 8'b1 << c;
            if (bus.mode) begin
               ptr_r  <= c + 3'd1;
               done_r <= (c == 3'd7);
            end else if (bus.ptr_clr) begin
               ptr_r <= '0;
            end
         end else if (bus.ptr_clr) begin
            ptr_r <= '0;
         end
      end
   end

`ifdef DEMUX8_PARITY_EN
   logic par_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_r <= 1'b0;
      end else if (bus.din_valid && bus.mode && c == 3'd7) begin
         par_r <= ^y_next;
      end
   end

   assign bus.frame_par = par_r;
`endif

   assign bus.y          = y_r;
   assign bus.y_strobe   = strobe_r;
   assign bus.ptr        = ptr_r;
   assign bus.frame_done = done_r;
endmodule

// File: tb/tb_demux_8_seq.sv
// tb/tb_demux_8_seq.sv - directed self-checking bench for demux_8_seq
module tb_demux_8_seq;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   fd_count;

   logic [7:0] exp_y;
   logic [2:0] exp_ptr;
   logic [7:0] exp_strobe;
   logic       exp_fd;
   logic       exp_par;

   demux_8_seq_if #(.W(1)) bus ();

   demux_8_seq #(.W(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, advance the scoreboard, sample #1 after the edge
   task automatic step(input logic v, input logic m, input logic [2:0] sel,
                       input logic d, input logic clr, input logic r);
      logic [2:0] c;
      bus.din_valid = v;
      bus.mode      = m;
      {bus.s2, bus.s1, bus.s0} = sel;
      bus.din       = d;
      bus.ptr_clr   = clr;
      rst           = r;
      c = m ? (clr ? 3'd0 : exp_ptr) : sel;
      if (r) begin
         exp_y = '0; exp_ptr = '0; exp_strobe = '0; exp_fd = 1'b0; exp_par = 1'b0;
      end else begin
         exp_strobe = '0;
         exp_fd     = 1'b0;
         if (v) begin
            exp_y[c]   = d;
            exp_strobe = 8'b1 << c;
            if (m) begin
               exp_fd  = (c == 3'd7);
               exp_ptr = c + 3'd1;
               if (c == 3'd7) exp_par = ^exp_y;
            end else if (clr) begin
               exp_ptr = '0;
            end
         end else if (clr) begin
            exp_ptr = '0;
         end
      end
      @(posedge clk);
      #1;
      if (bus.frame_done === 1'b1) fd_count++;
   endtask

   task automatic test_reset();
      step(1, 1, 3'd0, 1, 0, 1);
      step(1, 1, 3'd0, 1, 0, 1);
      checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got %h want 00", bus.y); end
      checks++; if (bus.y_strobe !== 8'h00) begin errors++; $display("FAIL reset_strobe got %h want 00", bus.y_strobe); end
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", bus.ptr); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
`ifdef DEMUX8_PARITY_EN
      checks++; if (bus.frame_par !== 1'b0) begin errors++; $display("FAIL reset_par got %b want 0", bus.frame_par); end
`endif
      step(0, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic test_addressed();
      step(1, 0, 3'd5, 1, 0, 0);
      checks++; if (bus.y !== 8'h20) begin errors++; $display("FAIL addr_y5 got %h want 20", bus.y); end
      checks++; if (bus.y_strobe !== 8'h20) begin errors++; $display("FAIL addr_strobe5 got %h want 20", bus.y_strobe); end
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL addr_ptr got %0d want 0", bus.ptr); end
      step(0, 0, 3'd5, 0, 0, 0);
      checks++; if (bus.y_strobe !== 8'h00) begin errors++; $display("FAIL addr_strobe_idle got %h want 00", bus.y_strobe); end
      checks++; if (bus.y !== 8'h20) begin errors++; $display("FAIL addr_hold got %h want 20", bus.y); end
      step(1, 0, 3'd7, 1, 0, 0);
      checks++; if (bus.y !== 8'hA0) begin errors++; $display("FAIL addr_y7 got %h want a0", bus.y); end
      checks++; if (bus.y_strobe !== 8'h80) begin errors++; $display("FAIL addr_strobe7 got %h want 80", bus.y_strobe); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL addr_fd got %b want 0", bus.frame_done); end
      step(0, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic test_auto_frame();
      logic [7:0] pattern;
      pattern = 8'b0100_1101;
      fd_count = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 3'd0, pattern[i], 0, 0);
         if (i < 7) begin
            checks++;
            if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL auto_fd_early ch %0d got %b want 0", i, bus.frame_done); end
         end
      end
      checks++; if (bus.y !== 8'h4D) begin errors++; $display("FAIL auto_y got %h want 4d", bus.y); end
      checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL auto_fd got %b want 1", bus.frame_done); end
      checks++; if (bus.y_strobe !== 8'h80) begin errors++; $display("FAIL auto_strobe got %h want 80", bus.y_strobe); end
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL auto_ptr got %0d want 0", bus.ptr); end
`ifdef DEMUX8_PARITY_EN
      checks++; if (bus.frame_par !== 1'b0) begin errors++; $display("FAIL auto_par got %b want 0", bus.frame_par); end
`endif
      step(0, 1, 3'd0, 0, 0, 0);
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL auto_fd_pulse got %b want 0", bus.frame_done); end
      checks++; if (fd_count !== 1) begin errors++; $display("FAIL auto_fd_count got %0d want 1", fd_count); end
   endtask

   task automatic test_gaps_wrap();
      logic [2:0] exp_seq [10];
      exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
      fd_count = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 3'd0, (i % 3 == 0) ? 1'b1 : 1'b0, 0, 0);
         checks++;
         if (bus.ptr !== exp_seq[i]) begin errors++; $display("FAIL gap_ptr[%0d] got %0d want %0d", i, bus.ptr, exp_seq[i]); end
         step(0, 1, 3'd0, 1, 0, 0);
         checks++;
         if (bus.y_strobe !== 8'h00) begin errors++; $display("FAIL gap_idle_strobe[%0d] got %h want 00", i, bus.y_strobe); end
      end
      checks++; if (fd_count !== 1) begin errors++; $display("FAIL gap_fd_count got %0d want 1", fd_count); end
      checks++; if (bus.y !== exp_y) begin errors++; $display("FAIL gap_y got %h want %h", bus.y, exp_y); end
`ifdef DEMUX8_PARITY_EN
      checks++; if (bus.frame_par !== exp_par) begin errors++; $display("FAIL gap_par got %b want %b", bus.frame_par, exp_par); end
`endif
   endtask

   task automatic test_ptr_clr();
      logic [7:0] y_before;
      for (int i = 0; i < 3; i++) step(1, 1, 3'd0, 0, 0, 0);
      checks++; if (bus.ptr !== 3'd5) begin errors++; $display("FAIL clr_setup got %0d want 5", bus.ptr); end
      step(1, 1, 3'd0, 1, 1, 0);
      checks++; if (bus.y_strobe !== 8'h01) begin errors++; $display("FAIL clr_coll_strobe got %h want 01", bus.y_strobe); end
      checks++; if (bus.ptr !== 3'd1) begin errors++; $display("FAIL clr_coll_ptr got %0d want 1", bus.ptr); end
      checks++; if (bus.y[0] !== 1'b1) begin errors++; $display("FAIL clr_coll_y0 got %b want 1", bus.y[0]); end
      step(1, 1, 3'd0, 1, 0, 0);
      step(1, 1, 3'd0, 1, 0, 0);
      checks++; if (bus.ptr !== 3'd3) begin errors++; $display("FAIL clr_ptr3 got %0d want 3", bus.ptr); end
      y_before = exp_y;
      step(0, 1, 3'd0, 1, 1, 0);
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL clr_alone_ptr got %0d want 0", bus.ptr); end
      checks++; if (bus.y !== y_before) begin errors++; $display("FAIL clr_alone_y got %h want %h", bus.y, y_before); end
      step(1, 1, 3'd0, 1, 0, 0);
      step(1, 1, 3'd0, 1, 0, 0);
      step(1, 0, 3'd6, 0, 1, 0);
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL clr_addr_ptr got %0d want 0", bus.ptr); end
      checks++; if (bus.y_strobe !== 8'h40) begin errors++; $display("FAIL clr_addr_strobe got %h want 40", bus.y_strobe); end
      step(1, 0, 3'd2, 1, 0, 0);
      step(1, 1, 3'd0, 0, 0, 0);
      checks++; if (bus.ptr !== 3'd1) begin errors++; $display("FAIL mode_resume_ptr got %0d want 1", bus.ptr); end
      checks++; if (bus.y !== exp_y) begin errors++; $display("FAIL clr_y got %h want %h", bus.y, exp_y); end
   endtask

   task automatic test_reset_mid_frame();
      step(0, 1, 3'd0, 0, 0, 1);
      fd_count = 0;
      for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 1, 0, 0);
      checks++; if (bus.ptr !== 3'd4) begin errors++; $display("FAIL mid_ptr4 got %0d want 4", bus.ptr); end
      step(1, 1, 3'd0, 1, 0, 1);
      checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL mid_rst_y got %h want 00", bus.y); end
      checks++; if (bus.y_strobe !== 8'h00) begin errors++; $display("FAIL mid_rst_strobe got %h want 00", bus.y_strobe); end
      checks++; if (bus.ptr !== 3'd0) begin errors++; $display("FAIL mid_rst_ptr got %0d want 0", bus.ptr); end
      for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 0, 0, 0);
      checks++; if (fd_count !== 0) begin errors++; $display("FAIL mid_no_fd got %0d want 0", fd_count); end
      for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 1, 0, 0);
      step(0, 1, 3'd0, 0, 0, 0);
      checks++; if (fd_count !== 1) begin errors++; $display("FAIL mid_fd_count got %0d want 1", fd_count); end
      checks++; if (bus.y !== 8'hF0) begin errors++; $display("FAIL mid_y got %h want f0", bus.y); end
`ifdef DEMUX8_PARITY_EN
      checks++; if (bus.frame_par !== 1'b0) begin errors++; $display("FAIL mid_par got %b want 0", bus.frame_par); end
`endif
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      bus.din = '0; bus.din_valid = 1'b0; bus.mode = 1'b0;
      bus.s0 = 1'b0; bus.s1 = 1'b0; bus.s2 = 1'b0; bus.ptr_clr = 1'b0;
      checks = 0; errors = 0; fd_count = 0;
      exp_y = '0; exp_ptr = '0; exp_strobe = '0; exp_fd = 1'b0; exp_par = 1'b0;
      test_reset();
      test_addressed();
      test_auto_frame();
      test_gaps_wrap();
      test_ptr_clr();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
